ppgen_pipe: RTL
===============

Name: ppgen_pipe

Overview:
- Registered partial-product generator that sits directly upstream of the 12x12 unsigned approximate compressor tree.
- Accepts operand pairs over a valid/ready handshake and forms the 144-bit AND-array partial-product bus in the row layout the compressor consumes.
- Presents that bus from a register stage with full back-pressure support (2-entry skid), so the combinational compressor sees stable, registered inputs.
- Also carries a sideband tag, a zero-operand flag and a transfer counter.

Parameters:
- W, 12: operand width; only 12 is supported; pp width is W*W = 144.
- TAG_W, 4: width of the sideband tag carried alongside each operand pair.
- CNT_W, 16: width of the output-transfer counter.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  operand pair offered.
- in_ready  output  1  block can accept; registered.
- in_a  input  12  multiplicand.
- in_b  input  12  multiplier.
- in_tag  input  TAG_W  sideband, passed through unchanged.
- out_valid  output  1  pp bus valid.
- out_ready  input  1  downstream accepts.
- out_pp  output  144  partial products.
- out_tag  output  TAG_W  tag of the current pp word.
- out_zero  output  1  in_a==0 or in_b==0 for the current word.
- xfer_cnt  output  CNT_W  count of completed output transfers.

Behaviour:
- Reset: one clock; reset is synchronous and active-low, sampled on the rising edge of clk via rst_n.
  - While rst_n=0 at an edge: out_valid=0, in_ready=1 after that edge, out_pp=0, out_tag=0, out_zero=0, xfer_cnt=0, skid entry invalid.
  - Reset mid-operation drops any held or skid word without emitting it; no handshake is honoured on the reset edge.
- Partial-product layout: out_pp[12*i + j] = a[j] & b[i] for i, j in 0..11. Row i = pp[12*i +: 12] carries weight i+j at bit j.
- Zero flag: out_zero = (a==0) | (b==0), computed at capture and registered with the word.
- Input handshake:
  - A transfer occurs when in_valid & in_ready at a rising edge.
  - in_ready = ~skid_valid, driven from a register, so there is no combinational path from out_ready to in_ready.
- Output handshake:
  - A transfer occurs when out_valid & out_ready.
  - While out_valid=1 and out_ready=0, out_pp, out_tag and out_zero hold stable.
  - out_valid never drops without a transfer, except on reset.
- Latency: 1 cycle. A word accepted at edge t appears with out_valid=1 after edge t when the output register is empty or transferring at t.
- Storage: output register (main) plus one skid entry. Each edge, in priority order:
  1. Main empty, or main transferring: main loads from the skid entry if it is valid, otherwise from the input when accepting. If the skid fed main and the input is also accepting, the skid reloads from the input.
  2. Main full and stalled, with an input accept: the input goes to the skid entry. in_ready falls after this edge.
  3. A simultaneous input accept and output transfer with the skid empty: main loads the new word. No bubble, throughput is 1 word/cycle.
- Ordering: strict FIFO; words leave in acceptance order; there is never loss or duplication.
- Full condition: main and skid both valid gives in_ready=0. in_valid is ignored while in_ready=0, and in_a/in_b/in_tag may change freely.
- Empty condition: out_valid=0. out_pp holds its last value and is don't-care to consumers.
- xfer_cnt: increments by 1 on each output transfer and wraps modulo 2^CNT_W (0xFFFF -> 0x0000). It never saturates.
- No combinational path from in_* to out_*.

Test Plan:
1. Reset, then a=0xFFF, b=0xFFF, out_ready=1 -> one cycle later out_valid=1, out_pp=all 144 ones, out_zero=0, xfer_cnt=1 after the next edge.
2. a=0x001, b=0x800, tag=0x5 -> only out_pp[132]=1, out_tag=0x5, out_zero=0. Then a=0x000, b=0xABC -> out_pp=0, out_zero=1.
3. Streaming 8 random pairs with out_ready=1 throughout -> 8 consecutive out_valid cycles with no bubbles; each out_pp matches the AND-array formula; the compressor fed from out_pp matches its golden model.
4. out_ready=0 while offering 3 pairs (A, B, C) -> A and B accepted, in_ready=0 after B; C held by the source; out_pp=A stable. Raise out_ready -> A, B, C emerge in order with no loss.
5. Assert rst_n=0 for 1 cycle while main and skid are both full -> out_valid=0, in_ready=1, xfer_cnt=0 after the edge; the held words are never emitted.
6. Force 65537 transfers -> xfer_cnt reads 0x0001.

Source files
------------

// File: rtl/ppgen_pipe.sv
// Registered 12x12 AND-array partial-product generator with a 2-entry skid
// output stage, sideband tag, zero-operand flag and output-transfer counter.
module ppgen_pipe #(
    parameter int unsigned W     = 12,
    parameter int unsigned TAG_W = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [W-1:0]       in_a,
    input  logic [W-1:0]       in_b,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [W*W-1:0]     out_pp,
    output logic [TAG_W-1:0]   out_tag,
    output logic               out_zero,
    output logic [CNT_W-1:0]   xfer_cnt
);

    localparam int unsigned PP_W = W * W;

    // Row i holds a masked by b[i]; bit j of row i has weight i+j.
    function automatic logic [PP_W-1:0] and_array(input logic [W-1:0] a,
                                                  input logic [W-1:0] b);
        logic [PP_W-1:0] r;
        r = '0;
        for (int i = 0; i < int'(W); i++) begin
            for (int j = 0; j < int'(W); j++) begin
                r[W*i+j] = a[j] & b[i];
            end
        end
        return r;
    endfunction

    // Main (output) register
    logic              main_valid_q, main_valid_d;
    logic [PP_W-1:0]   main_pp_q,    main_pp_d;
    logic [TAG_W-1:0]  main_tag_q,   main_tag_d;
    logic              main_zero_q,  main_zero_d;

    // Skid entry keeps raw operands; the pp is formed when it moves to main
    logic              skid_valid_q, skid_valid_d;
    logic [W-1:0]      skid_a_q,     skid_a_d;
    logic [W-1:0]      skid_b_q,     skid_b_d;
    logic [TAG_W-1:0]  skid_tag_q,   skid_tag_d;

    logic              in_ready_q,   in_ready_d;
    logic [CNT_W-1:0]  cnt_q,        cnt_d;

    logic              in_acc;
    logic              out_xfer;
    logic              main_free;

    // Next-state: load main from skid first (FIFO order), else from input
    always_comb begin
        main_valid_d = main_valid_q;
        main_pp_d    = main_pp_q;
        main_tag_d   = main_tag_q;
        main_zero_d  = main_zero_q;
        skid_valid_d = skid_valid_q;
        skid_a_d     = skid_a_q;
        skid_b_d     = skid_b_q;
        skid_tag_d   = skid_tag_q;
        cnt_d        = cnt_q;

        in_acc    = in_valid & in_ready_q;
        out_xfer  = main_valid_q & out_ready;
        main_free = ~main_valid_q | out_ready;

        if (main_free) begin
            if (skid_valid_q) begin
                main_valid_d = 1'b1;
                main_pp_d    = and_array(skid_a_q, skid_b_q);
                main_tag_d   = skid_tag_q;
                main_zero_d  = (skid_a_q == '0) | (skid_b_q == '0);
                skid_valid_d = in_acc;
                if (in_acc) begin
                    skid_a_d   = in_a;
                    skid_b_d   = in_b;
                    skid_tag_d = in_tag;
                end
            end else if (in_acc) begin
                main_valid_d = 1'b1;
                main_pp_d    = and_array(in_a, in_b);
                main_tag_d   = in_tag;
                main_zero_d  = (in_a == '0) | (in_b == '0);
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (in_acc) begin
            skid_valid_d = 1'b1;
            skid_a_d     = in_a;
            skid_b_d     = in_b;
            skid_tag_d   = in_tag;
        end

        in_ready_d = ~skid_valid_d;

        if (out_xfer) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            main_pp_q    <= '0;
            main_tag_q   <= '0;
            main_zero_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_a_q     <= '0;
            skid_b_q     <= '0;
            skid_tag_q   <= '0;
            in_ready_q   <= 1'b1;
            cnt_q        <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_pp_q    <= main_pp_d;
            main_tag_q   <= main_tag_d;
            main_zero_q  <= main_zero_d;
            skid_valid_q <= skid_valid_d;
            skid_a_q     <= skid_a_d;
            skid_b_q     <= skid_b_d;
            skid_tag_q   <= skid_tag_d;
            in_ready_q   <= in_ready_d;
            cnt_q        <= cnt_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = main_valid_q;
    assign out_pp    = main_pp_q;
    assign out_tag   = main_tag_q;
    assign out_zero  = main_zero_q;
    assign xfer_cnt  = cnt_q;

endmodule
